// File: rtl/rotary_step_controller.sv
// Rotary encoder front end: per-pin sync + debounce, detent decode, command FIFO with
// valid/ready issue, and the position counter that moves only on accepted commands.

module rsc_pin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic sample,
  output logic deb
);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic        cand_q, cand_d;
  logic        deb_q, deb_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sample != cand_q) begin
      cand_d = sample;
      cnt_d  = '0;
    end else if (hold) begin
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      // counter parks at the threshold; debounced value follows the candidate
      deb_d  = cand_q;
    end else begin
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand_q <= 1'b0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb = deb_q;
endmodule

module rotary_step_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int POS_WIDTH       = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 locked,
  input  logic [1:0]           rotary,
  output logic                 cmd_valid,
  output logic                 cmd_dir,
  input  logic                 cmd_ready,
  output logic [POS_WIDTH-1:0] position,
  output logic                 dropped
);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            prev_q, prev_d;
  logic [1:0]            deb;
  logic                  hold;
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [POS_WIDTH-1:0]  pos_q, pos_d;
  logic                  dropped_q, dropped_d;
  logic                  cw_evt, ccw_evt, push, wr, hs, full;

  assign hold = ~locked;

  for (genvar i = 0; i < 2; i++) begin : g_pin
    rsc_pin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock  (clock),
      .reset  (reset),
      .hold   (hold),
      .sample (sync2_q[i]),
      .deb    (deb[i])
    );
  end

  assign cmd_valid = (count_q != '0);
  assign cmd_dir   = mem_q[rptr_q];
  assign position  = pos_q;
  assign dropped   = dropped_q;

  always_comb begin
    sync1_d   = rotary;
    sync2_d   = sync1_q;
    // prev always tracks deb, so nothing can fire on the first cycle after relock
    prev_d    = deb;
    cw_evt    = locked && (prev_q == 2'b10) && (deb == 2'b00);
    ccw_evt   = locked && (prev_q == 2'b01) && (deb == 2'b00);
    push      = cw_evt | ccw_evt;
    full      = (count_q == CNTW'(FIFO_DEPTH));
    // a handshake only counts while locked, so a lock drop never half-applies a step
    hs        = cmd_valid & cmd_ready & locked;
    wr        = push & (~full | hs);
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    pos_d     = pos_q;
    dropped_d = dropped_q | (push & ~wr);

    if (!locked) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (hs) begin
        rptr_d = rptr_q + AW'(1);
        pos_d  = mem_q[rptr_q] ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
      end
      if (wr) begin
        mem_d[wptr_q] = cw_evt;
        wptr_d        = wptr_q + AW'(1);
      end
      count_d = count_q + CNTW'(wr) - CNTW'(hs);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      mem_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pos_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      pos_q     <= pos_d;
      dropped_q <= dropped_d;
    end
  end
endmodule

// File: tb/tb_rotary_step_controller.sv
// Directed bench for rotary_step_controller: detent decode, debounce, wrap, overflow, lock loss.

module tb_rotary_step_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       locked = 1'b0;
  logic [1:0] rotary = 2'b00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, cmd_dir, dropped;
  logic [2:0] position;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  rotary_step_controller #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .POS_WIDTH(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .locked    (locked),
    .rotary    (rotary),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .position  (position),
    .dropped   (dropped)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (reset && locked && cmd_valid && cmd_ready) hs_cnt++;

  // all tasks start and end right at a posedge
  task automatic set_pins(input logic [1:0] v, input int n);
    #1 rotary = v;
    repeat (n) @(posedge clock);
  endtask

  task automatic detent(input bit cw);
    if (cw) begin
      set_pins(2'b01, 40); set_pins(2'b11, 40); set_pins(2'b10, 40); set_pins(2'b00, 40);
    end else begin
      set_pins(2'b10, 40); set_pins(2'b11, 40); set_pins(2'b01, 40); set_pins(2'b00, 40);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    locked = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1 rotary = 2'($urandom_range(0, 3));
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
      n_checks++; if (position !== 3'd0) begin n_fail++; $display("FAIL reset_pos got %0d want 0", position); end
      n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b want 0", dropped); end
    end
    rotary = 2'b00;
    @(posedge clock);
    #1 reset = 1'b1;
    begin
      int h0 = hs_cnt;
      int vseen = 0;
      cmd_ready = 1'b1;
      repeat (60) begin
        @(posedge clock);
        #1 if (cmd_valid) vseen++;
      end
      n_checks++; if (vseen != 0 || hs_cnt != h0) begin n_fail++; $display("FAIL idle_no_cmd got %0d valid cycles want 0", vseen); end
    end
    @(posedge clock);
  endtask

  task automatic test_cw_detent;
    int h0 = hs_cnt;
    int lat = 40;
    bit seen = 0;
    cmd_ready = 1'b1;
    set_pins(2'b01, 40); set_pins(2'b11, 40); set_pins(2'b10, 40);
    #1 rotary = 2'b00;
    @(posedge clock);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clock);
      #1 if (cmd_valid) begin seen = 1; lat = i; end
    end
    n_checks++; if (lat != 19) begin n_fail++; $display("FAIL cw_latency got %0d want 19", lat); end
    n_checks++; if (cmd_dir !== 1'b1) begin n_fail++; $display("FAIL cw_dir got %b want 1", cmd_dir); end
    @(posedge clock);
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cw_pulse_len got %b want 0", cmd_valid); end
    n_checks++; if (position !== 3'd1) begin n_fail++; $display("FAIL cw_pos got %0d want 1", position); end
    repeat (30) @(posedge clock);
    #1;
    n_checks++; if (hs_cnt - h0 != 1) begin n_fail++; $display("FAIL cw_hs_count got %0d want 1", hs_cnt - h0); end
    @(posedge clock);
  endtask

  task automatic test_bounce;
    int h0 = hs_cnt;
    logic [1:0] cur = 2'b00;
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    foreach (seq[k]) begin
      repeat (5) begin
        set_pins(cur ^ 2'b01, 3);
        set_pins(cur, 3);
      end
      set_pins(seq[k], 40);
      cur = seq[k];
    end
    #1;
    n_checks++; if (hs_cnt - h0 != 1) begin n_fail++; $display("FAIL bounce_cmds got %0d want 1", hs_cnt - h0); end
    n_checks++; if (position !== 3'd2) begin n_fail++; $display("FAIL bounce_pos got %0d want 2", position); end
    @(posedge clock);
  endtask

  task automatic test_wrap_ccw;
    int h0;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (position !== 3'd0) begin n_fail++; $display("FAIL midreset_pos got %0d want 0", position); end
    #2 reset = 1'b1;
    @(posedge clock);
    h0 = hs_cnt;
    detent(1'b0);
    #1;
    n_checks++; if (position !== 3'd7) begin n_fail++; $display("FAIL ccw_wrap_pos got %0d want 7", position); end
    detent(1'b1);
    #1;
    n_checks++; if (position !== 3'd0) begin n_fail++; $display("FAIL cw_wrap_pos got %0d want 0", position); end
    repeat (7) detent(1'b1);
    #1;
    n_checks++; if (position !== 3'd7) begin n_fail++; $display("FAIL eight_cw_pos got %0d want 7", position); end
    n_checks++; if (hs_cnt - h0 != 9) begin n_fail++; $display("FAIL wrap_hs_count got %0d want 9", hs_cnt - h0); end
    @(posedge clock);
  endtask

  task automatic test_overflow;
    int h0;
    cmd_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      detent(1'b1);
      #1;
      if (k == 4) begin
        n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL full_no_drop got %b want 0", dropped); end
        n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", cmd_valid); end
      end
      if (k == 5) begin
        n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL overflow_drop got %b want 1", dropped); end
      end
      @(posedge clock);
    end
    #1;
    n_checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 1'b1) begin n_fail++; $display("FAIL bp_head got valid=%b dir=%b want 1/1", cmd_valid, cmd_dir); end
    n_checks++; if (position !== 3'd7) begin n_fail++; $display("FAIL bp_pos_hold got %0d want 7", position); end
    h0 = hs_cnt;
    cmd_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    n_checks++; if (hs_cnt - h0 != 4) begin n_fail++; $display("FAIL drain_hs got %0d want 4", hs_cnt - h0); end
    n_checks++; if (position !== 3'd3) begin n_fail++; $display("FAIL drain_pos got %0d want 3", position); end
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got %b want 1", dropped); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", cmd_valid); end
    cmd_ready = 1'b0;
    @(posedge clock);
  endtask

  task automatic test_lock_loss;
    int h0;
    detent(1'b1);
    detent(1'b1);
    #1;
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL lock_queued got %b want 1", cmd_valid); end
    locked = 1'b0;
    @(posedge clock);
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL unlock_flush got %b want 0", cmd_valid); end
    repeat (10) @(posedge clock);
    #1;
    n_checks++; if (position !== 3'd3) begin n_fail++; $display("FAIL unlock_pos got %0d want 3", position); end
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL unlock_dropped got %b want 1", dropped); end
    locked    = 1'b1;
    cmd_ready = 1'b1;
    h0 = hs_cnt;
    repeat (50) @(posedge clock);
    #1;
    n_checks++; if (hs_cnt - h0 != 0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL relock_spurious got %0d cmds want 0", hs_cnt - h0); end
    n_checks++; if (position !== 3'd3) begin n_fail++; $display("FAIL relock_pos got %0d want 3", position); end
    @(posedge clock);
  endtask

  task automatic test_reset_mid;
    cmd_ready = 1'b0;
    detent(1'b1);
    #1;
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", cmd_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b0 || position !== 3'd0 || dropped !== 1'b0)
      begin n_fail++; $display("FAIL async_reset got v=%b p=%0d d=%b want 0/0/0", cmd_valid, position, dropped); end
    #2 reset = 1'b1;
    @(posedge clock);
  endtask

  initial begin
    @(posedge clock);
    test_reset();
    test_cw_detent();
    test_bounce();
    test_wrap_ccw();
    test_overflow();
    test_lock_loss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
